// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial pattern detector.
// Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit
// per clock with no gap between back-to-back words. stall_i freezes the stream.
//
// Ports:
//   clk_i        in   rising-edge clock
//   reset_i      in   synchronous, active-high reset
//   word_i       in   parallel word, sampled on handshake (valid_i && ready_o)
//   valid_i      in   word_i is valid
//   ready_o      out  word can be accepted this cycle (combinational)
//   stall_i      in   freeze the serial stream while high
//   data_o       out  serial bit (registered)
//   bit_valid_o  out  data_o carries a payload bit (registered)
//   last_o       out  data_o is the final bit of the word (registered)
//   busy_o       out  a word is in flight (registered)
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             stall_i,
    output logic             data_o,
    output logic             bit_valid_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_data;
    logic             r_bit_valid;
    logic             r_last;
    logic             r_busy;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_data_nxt;
    logic             w_bit_valid_nxt;
    logic             w_last_nxt;
    logic             w_busy_nxt;
    logic             w_at_last;
    logic             w_load;

    // Accept a word when idle, or when the final bit of the current word is out.
    assign w_at_last = (r_cnt == CNT_LAST);
    assign ready_o   = !reset_i && !stall_i && ((r_state == S_IDLE) || w_at_last);
    assign w_load    = valid_i && ready_o;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_cnt_nxt       = r_cnt;
        w_data_nxt      = r_data;
        w_bit_valid_nxt = 1'b0;
        w_last_nxt      = r_last;
        w_busy_nxt      = r_busy;

        if (w_load) begin
            // The first bit goes straight to data_o; the register keeps the rest.
            w_state_nxt     = S_SHIFT;
            w_cnt_nxt       = '0;
            w_bit_valid_nxt = 1'b1;
            w_last_nxt      = 1'b0;
            w_busy_nxt      = 1'b1;
            if (MSB_FIRST) begin
                w_data_nxt = word_i[WIDTH-1];
                w_sreg_nxt = word_i << 1;
            end else begin
                w_data_nxt = word_i[0];
                w_sreg_nxt = word_i >> 1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_data_nxt = IDLE_LEVEL;
                    w_last_nxt = 1'b0;
                    w_busy_nxt = 1'b0;
                end
                S_SHIFT: begin
                    if (stall_i) begin
                        // Hold everything; only bit_valid drops.
                        w_bit_valid_nxt = 1'b0;
                    end else if (w_at_last) begin
                        w_state_nxt = S_IDLE;
                        w_data_nxt  = IDLE_LEVEL;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt       = r_cnt + CNT_W'(1);
                        w_bit_valid_nxt = 1'b1;
                        w_last_nxt      = (r_cnt == CNT_PENULT);
                        if (MSB_FIRST) begin
                            w_data_nxt = r_sreg[WIDTH-1];
                            w_sreg_nxt = r_sreg << 1;
                        end else begin
                            w_data_nxt = r_sreg[0];
                            w_sreg_nxt = r_sreg >> 1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_data_nxt  = IDLE_LEVEL;
                    w_last_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_data      <= IDLE_LEVEL;
            r_bit_valid <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data      <= w_data_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_last      <= w_last_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign data_o      = r_data;
    assign bit_valid_o = r_bit_valid;
    assign last_o      = r_last;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: an MSB-first instance (idle level 0) and an
// LSB-first instance (idle level 1) share one stimulus stream and are compared
// every cycle against a word/bit-position reference model.
module tb_bit_serializer;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic       stall_i;
    logic [7:0] word_i;

    logic ready_m, data_m, bv_m, last_m, busy_m;
    logic ready_l, data_l, bv_l, last_l, busy_l;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: is a word in flight, which bit of it is on the wire,
    // and whether the wire is currently stalled.
    bit         m_act;
    int         m_pos;
    logic [7:0] m_word;
    bit         m_stalled;

    always #5 clk_i = ~clk_i;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk_i(clk_i), .reset_i(reset_i), .word_i(word_i), .valid_i(valid_i),
        .ready_o(ready_m), .stall_i(stall_i), .data_o(data_m),
        .bit_valid_o(bv_m), .last_o(last_m), .busy_o(busy_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk_i(clk_i), .reset_i(reset_i), .word_i(word_i), .valid_i(valid_i),
        .ready_o(ready_l), .stall_i(stall_i), .data_o(data_l),
        .bit_valid_o(bv_l), .last_o(last_l), .busy_o(busy_l)
    );

    function automatic logic exp_bit(input logic [7:0] w, input int p, input bit msb);
        logic [7:0] t;
        t = w;
        return msb ? t[7-p] : t[p];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check ready_o,
    // then advance the model across the rising edge.
    task automatic cyc(input logic r, input logic s, input logic v, input logic [7:0] w);
        logic e_rdy;
        @(negedge clk_i);
        chk("busy_msb", busy_m, m_act);
        chk("bvalid_msb", bv_m, m_act && !m_stalled);
        chk("last_msb", last_m, m_act && (m_pos == 7));
        chk("data_msb", data_m, m_act ? exp_bit(m_word, m_pos, 1'b1) : 1'b0);
        chk("busy_lsb", busy_l, m_act);
        chk("bvalid_lsb", bv_l, m_act && !m_stalled);
        chk("last_lsb", last_l, m_act && (m_pos == 7));
        chk("data_lsb", data_l, m_act ? exp_bit(m_word, m_pos, 1'b0) : 1'b1);
        reset_i = r;
        stall_i = s;
        valid_i = v;
        word_i  = w;
        e_rdy = !r && !s && (!m_act || (m_pos == 7));
        #1;
        chk("ready_msb", ready_m, e_rdy);
        chk("ready_lsb", ready_l, e_rdy);
        @(posedge clk_i);
        if (r) begin
            m_act = 1'b0; m_pos = 0; m_stalled = 1'b0;
        end else if (s) begin
            if (m_act) m_stalled = 1'b1;
        end else if (v && e_rdy) begin
            m_act = 1'b1; m_pos = 0; m_word = w; m_stalled = 1'b0;
        end else if (m_act) begin
            m_stalled = 1'b0;
            if (m_pos == 7) m_act = 1'b0;
            else m_pos++;
        end
    endtask

    initial begin
        reset_i = 1'b1;
        stall_i = 1'b0;
        valid_i = 1'b0;
        word_i  = 8'h00;
        repeat (2) @(posedge clk_i);
        m_act = 1'b0; m_pos = 0; m_word = 8'h00; m_stalled = 1'b0;

        // Reset held: ready low, outputs at idle.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);

        // Idle hold with toggling word_i and valid_i low.
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, (i % 2 == 1) ? 8'hFF : 8'h00);

        // Single word A5.
        cyc(1'b0, 1'b0, 1'b1, 8'hA5);
        repeat (12) cyc(1'b0, 1'b0, 1'b0, 8'hA5);

        // Back-to-back F0 then 0F with valid held high.
        cyc(1'b0, 1'b0, 1'b1, 8'hF0);
        repeat (8) cyc(1'b0, 1'b0, 1'b1, 8'h0F);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Word 01: LSB-first instance emits 1 then seven 0s.
        cyc(1'b0, 1'b0, 1'b1, 8'h01);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Stall for 3 cycles while bit index 3 of A5 is on the wire.
        cyc(1'b0, 1'b0, 1'b1, 8'hA5);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'hA5);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 8'h3C);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Stall while idle only blocks ready_o.
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 8'h77);

        // Reset at bit index 4 of FF, then a fresh word 81.
        cyc(1'b0, 1'b0, 1'b1, 8'hFF);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'hFF);
        cyc(1'b1, 1'b0, 1'b0, 8'hFF);
        cyc(1'b0, 1'b0, 1'b1, 8'h81);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomized traffic with occasional reset and frequent stalls.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                8'($urandom));
        end
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
